// File: rtl/serial_adder.sv
// Bit-serial ripple adder with valid/ready handshakes on both sides.
// One full-adder bit is resolved per clock, LSB first, so a result takes WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;

    logic             accept;
    logic             release_out;
    logic             last_bit;
    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH-1:0] res_next;

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);

    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;
    assign last_bit    = (cnt == CNT_W'(WIDTH - 1));

    assign bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    assign bit_carry = ((a_sh[0] ^ b_sh[0]) & carry) | (a_sh[0] & b_sh[0]);
    assign res_next  = {bit_sum, res_sh[WIDTH-1:1]};

    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        next_state = state;
        unique case (state)
            IDLE: if (accept) next_state = RUN;
            RUN:  if (last_bit) next_state = DONE;
            DONE: if (release_out) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath registers: operand/result shifters, carry and bit counter.
    always_ff @(posedge clk) begin
        // NOTE: the datapath is reset explicitly because a reset must leave
        // the result register and counter in a known cleared state.
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            carry  <= c_in;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            carry  <= bit_carry;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Output registers load only on the final bit and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if ((state == RUN) && last_bit) begin
            sum_q   <= res_next;
            c_out_q <= bit_carry;
            // carry holds the carry into the MSB on this edge
            ovf_q   <= carry ^ bit_carry;
        end
    end

endmodule
